// File: rtl/alu_mdu.sv
// EX-stage execution unit: registered single-cycle ALU plus iterative
// multiply/divide producing HI/LO, all behind a valid/ready result register.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             md_en,
  input  logic [1:0]       md_op,
  input  logic [3:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CNTW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   acc, quo, mag_m, a_hold;
  logic               neg_q, neg_r, b_zero;
  logic               accept, md_sgn, md_div;
  logic [SHW-1:0]     sa, sa_m1;
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   shl1, shr1, alu_r, mag_a, mag_b, fin_hi, fin_lo;
  logic               alu_c, alu_v;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  // One shift-add (multiply) or restoring-subtract (divide) step on {acc, quo}.
  function automatic logic [2*WIDTH-1:0] md_step(input logic [WIDTH-1:0] hi_w,
                                                 input logic [WIDTH-1:0] lo_w,
                                                 input logic [WIDTH-1:0] m,
                                                 input logic             div);
    logic [WIDTH:0]     t, d;
    logic [2*WIDTH-1:0] res;
    if (div) begin
      t = {hi_w, lo_w[WIDTH-1]};
      d = t - {1'b0, m};
      if (t >= {1'b0, m}) res = {d[WIDTH-1:0], lo_w[WIDTH-2:0], 1'b1};
      else                res = {t[WIDTH-1:0], lo_w[WIDTH-2:0], 1'b0};
    end else begin
      t   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, m} : '0);
      res = {t, lo_w[WIDTH-1:1]};
    end
    return res;
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  assign sa     = a[SHW-1:0];
  assign sa_m1  = sa - SHW'(1);
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign shl1   = b << sa_m1;
  assign shr1   = b >> sa_m1;
  assign md_sgn = md_op[0];
  assign md_div = md_op[1];
  assign mag_a  = magnitude(a, md_sgn);
  assign mag_b  = magnitude(b, md_sgn);

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (aluc)
      4'b0000: begin alu_r = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      4'b0010: begin
        alu_r = add_w[WIDTH-1:0];
        alu_v = (a[WIDTH-1] == b[WIDTH-1]) & (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin alu_r = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
      4'b0011: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_v = (a[WIDTH-1] != b[WIDTH-1]) & (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: alu_r = a & b;
      4'b0101: alu_r = a | b;
      4'b0110: alu_r = a ^ b;
      4'b0111: alu_r = ~(a | b);
      4'b1000, 4'b1001: alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b1011: alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1010: begin alu_r = {{(WIDTH-1){1'b0}}, sub_w[WIDTH]}; alu_c = sub_w[WIDTH]; end
      4'b1100: begin alu_r = $signed(b) >>> sa; alu_c = (sa != '0) & shr1[0]; end
      4'b1101: begin alu_r = b >> sa;           alu_c = (sa != '0) & shr1[0]; end
      default: begin alu_r = b << sa;           alu_c = (sa != '0) & shl1[WIDTH-1]; end
    endcase
  end

  // Finishing cycle: sign fix on magnitudes, divide-by-zero override.
  assign prod_fix = neg_q ? -{acc, quo} : {acc, quo};

  always_comb begin
    if (state == DIV) begin
      fin_lo = b_zero ? '1 : (neg_q ? -quo : quo);
      fin_hi = b_zero ? a_hold : (neg_r ? -acc : acc);
    end else begin
      {fin_hi, fin_lo} = prod_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      r        <= '0;
      hi       <= '0;
      lo       <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      if (md_en) begin
        // The first iteration runs on the accept edge, so WIDTH-1 more
        // plus the finishing cycle follow in MUL/DIV.
        state  <= md_div ? DIV : MUL;
        cnt    <= '0;
        neg_q  <= md_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r  <= md_sgn & md_div & a[WIDTH-1];
        b_zero <= md_div & (b == '0);
        a_hold <= a;
        mag_m  <= md_div ? mag_b : mag_a;
        {acc, quo} <= md_step('0, md_div ? mag_a : mag_b, md_div ? mag_b : mag_a, md_div);
        if (md_div) div_zero <= 1'b0;
      end else begin
        state    <= DONE;
        r        <= alu_r;
        zero     <= (alu_r == '0);
        carry    <= alu_c;
        negative <= alu_r[WIDTH-1];
        overflow <= alu_v;
      end
    end else begin
      case (state)
        DONE: if (out_ready) state <= IDLE;
        MUL, DIV: begin
          if (cnt == CNTW'(WIDTH-1)) begin
            state    <= DONE;
            hi       <= fin_hi;
            lo       <= fin_lo;
            r        <= fin_lo;
            zero     <= (fin_lo == '0);
            negative <= fin_lo[WIDTH-1];
            carry    <= 1'b0;
            overflow <= 1'b0;
            if (state == DIV) div_zero <= b_zero;
          end else begin
            {acc, quo} <= md_step(acc, quo, mag_m, state == DIV);
            cnt        <= cnt + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
